mskaes_key_loader: RTL and testbench

MSKAES_KEY_LOADER -- requirements
Module: MSKaes_key_loader

---
 rtl/mskaes_key_loader_pkg.sv | 27 ++
 rtl/mskaes_key_loader_word.sv | 21 ++
 rtl/mskaes_key_loader.sv | 113 +++++++++++
 tb/tb_mskaes_key_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mskaes_key_loader_pkg.sv
// rtl/mskaes_key_loader_pkg.sv - shared encodings and word-count constants for the masked AES key loader
package mskaes_key_loader_pkg;

  localparam logic [1:0] MODE_128 = 2'd0;
  localparam logic [1:0] MODE_192 = 2'd1;
  localparam logic [1:0] MODE_256 = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] WORDS_128 = 4'd4;
  localparam logic [3:0] WORDS_192 = 4'd6;
  localparam logic [3:0] WORDS_256 = 4'd8;

  // Reserved mode 3 falls through to the AES-128 word count.
  function automatic logic [3:0] target_words(input logic [1:0] m);
    case (m)
      MODE_192: return WORDS_192;
      MODE_256: return WORDS_256;
      default:  return WORDS_128;
    endcase
  endfunction

endpackage

// File: rtl/mskaes_key_loader_word.sv
// rtl/mskaes_key_loader_word.sv - one 32-bit masked key column register, enable-gated with synchronous clear
module mskaes_key_loader_word #(
  parameter int d = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [32*d-1:0] din,
  output logic [32*d-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= din;
    end
  end

endmodule

// File: rtl/mskaes_key_loader.sv
// rtl/mskaes_key_loader.sv - collects masked key columns into a full sh_key; long keys need MSKAES_KEY_LOADER_LONGKEY_EN
module mskaes_key_loader
  import mskaes_key_loader_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*d-1:0]  in_sh_word,
  output logic             key_valid,
  input  logic             key_consume,
  output logic [1:0]       key_mode,
  output logic [256*d-1:0] sh_key
);

  localparam int WW = 32 * d;
`ifdef MSKAES_KEY_LOADER_LONGKEY_EN
  localparam int NWORDS = 8;
`else
  localparam int NWORDS = 4;
`endif

  state_t     state, state_nxt;
  logic [2:0] wcnt, wcnt_nxt;
  logic [1:0] mode_q, mode_eff;
  logic [3:0] tgt;
  logic       xfer, first_xfer;

`ifdef MSKAES_KEY_LOADER_LONGKEY_EN
  assign mode_eff = (mode == 2'd3) ? MODE_128 : mode;
  assign tgt      = target_words((state == ST_EMPTY) ? mode_eff : mode_q);
`else
  logic unused_mode;
  assign unused_mode = ^mode;
  assign mode_eff    = MODE_128;
  assign tgt         = WORDS_128;
`endif

  assign xfer       = in_valid & in_ready;
  assign first_xfer = xfer & (state == ST_EMPTY);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    in_ready  = 1'b1;
    case (state)
      ST_EMPTY: begin
        if (in_valid) begin
          wcnt_nxt  = 3'd1;
          state_nxt = (tgt == 4'd1) ? ST_FULL : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // wcnt holds at the last index so it never has to represent 8.
        if (in_valid) begin
          if ({1'b0, wcnt} + 4'd1 >= tgt) begin
            state_nxt = ST_FULL;
          end else begin
            wcnt_nxt = wcnt + 3'd1;
          end
        end
      end
      ST_FULL: begin
        in_ready = 1'b0;
        if (key_consume) begin
          state_nxt = ST_EMPTY;
          wcnt_nxt  = 3'd0;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      wcnt   <= 3'd0;
      mode_q <= MODE_128;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (first_xfer) begin
        mode_q <= mode_eff;
      end
    end
  end

  assign key_valid = (state == ST_FULL);
  assign key_mode  = mode_q;

  // The first word of a key clears every other column so short keys leave a zero sharing above.
  for (genvar i = 0; i < NWORDS; i++) begin : g_word
    logic en, clr;
    assign en  = (i == 0) ? first_xfer : (xfer && (state == ST_LOAD) && (wcnt == 3'(i)));
    assign clr = (i != 0) && first_xfer;
    mskaes_key_loader_word #(.d(d)) u_word (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .din (in_sh_word),
      .q   (sh_key[WW*i +: WW])
    );
  end

`ifndef MSKAES_KEY_LOADER_LONGKEY_EN
  assign sh_key[256*d-1:128*d] = '0;
`endif

endmodule

// File: tb/tb_mskaes_key_loader.sv
// tb/tb_mskaes_key_loader.sv - scoreboard bench for mskaes_key_loader
module tb_mskaes_key_loader;

  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [1:0]     mode = 2'd0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [32*D-1:0] in_sh_word = '0;
  logic           key_valid;
  logic           key_consume = 1'b0;
  logic [1:0]     key_mode;
  logic [256*D-1:0] sh_key;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   mode;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic         prev_kv = 1'b0;
  logic [255:0] k029;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mskaes_key_loader #(.d(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sh_word  (in_sh_word),
    .key_valid   (key_valid),
    .key_consume (key_consume),
    .key_mode    (key_mode),
    .sh_key      (sh_key)
  );

  function automatic logic [255:0] recomb(input logic [256*D-1:0] s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = s[16*i +: 8] ^ s[16*i+8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mask_word(input logic [31:0] p);
    logic [63:0] w;
    logic [7:0]  m;
    for (int j = 0; j < 4; j++) begin
      m = 8'($urandom);
      w[16*j +: 16] = {p[8*j +: 8] ^ m, m};
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (key_valid && !prev_kv) begin
      if (sb.size() == 0) begin
        check("unexpected_key_valid", 256'd1, 256'd0);
      end else begin
        e = sb.pop_front();
        check("key_bytes", recomb(sh_key), e.key);
        check("key_mode", 256'(key_mode), 256'(e.mode));
        check("key_valid_latency", 256'(cyc), 256'(e.cyc + 1));
      end
    end
    prev_kv <= key_valid;
  end

  task automatic xfer(input logic [31:0] p, input logic [1:0] m, input bit last,
                      input logic [255:0] k, input logic [1:0] em);
    int n = 0;
    in_valid   = 1'b1;
    in_sh_word = mask_word(p);
    mode       = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 256'd0, 256'd1);
    if (last) sb.push_back('{key: k, mode: em, cyc: cyc});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [1:0] m0, input logic [1:0] mn, input int nwords,
                          input logic [7:0] base, input logic [1:0] em, input bit gaps,
                          output logic [255:0] k);
    logic [31:0] p;
    k = '0;
    for (int w = 0; w < nwords; w++) begin
      for (int j = 0; j < 4; j++) p[8*j +: 8] = base + 8'(4*w + j);
      k[32*w +: 32] = p;
      xfer(p, (w == 0) ? m0 : mn, (w == nwords - 1), k, em);
      if (gaps) @(negedge clk);
    end
  endtask

  task automatic do_consume;
    key_consume = 1'b1;
    @(negedge clk);
    key_consume = 1'b0;
    check("consume_key_valid", 256'(key_valid), 256'd0);
  endtask

  initial begin
    logic [255:0] kk;
    logic [31:0]  p;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'd1);
    check("rst_key_valid", 256'(key_valid), 256'd0);
    check("rst_key_mode", 256'(key_mode), 256'd0);
    check("rst_sh_key_zero", 256'(|sh_key), 256'd0);
    rst = 1'b0;

    // AES-128 back-to-back, then FULL holds off new data
    load_key(2'd0, 2'd0, 4, 8'h00, 2'd0, 1'b0, k029);
    check("full_in_ready", 256'(in_ready), 256'd0);
    in_valid   = 1'b1;
    in_sh_word = mask_word(32'hdeadbeef);
    mode       = 2'd2;
    for (int c = 0; c < 5; c++) begin
      check("full_hold_key", recomb(sh_key), k029);
      check("full_hold_in_ready", 256'(in_ready), 256'd0);
      @(negedge clk);
    end
    key_consume = 1'b1;
    check("consume_cycle_in_ready", 256'(in_ready), 256'd0);
    @(negedge clk);
    key_consume = 1'b0;
    check("empty_key_valid", 256'(key_valid), 256'd0);
    check("empty_in_ready", 256'(in_ready), 256'd1);

    // mode switched to 2 after the first word is ignored
    load_key(2'd0, 2'd2, 4, 8'h50, 2'd0, 1'b0, kk);
    check("mode_change_key", recomb(sh_key), kk);
    do_consume();

    // aborted mode-1 load then reset
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < 4; j++) p[8*j +: 8] = 8'hA0 + 8'(4*w + j);
      xfer(p, 2'd1, 1'b0, '0, 2'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_sh_key_zero", 256'(|sh_key), 256'd0);
    check("abort_in_ready", 256'(in_ready), 256'd1);
    check("abort_key_valid", 256'(key_valid), 256'd0);
    rst = 1'b0;
    load_key(2'd0, 2'd0, 4, 8'h40, 2'd0, 1'b0, kk);
    check("post_abort_upper_zero", 256'(recomb(sh_key) >> 128), 256'd0);
    do_consume();

`ifdef MSKAES_KEY_LOADER_LONGKEY_EN
    load_key(2'd2, 2'd2, 8, 8'h80, 2'd2, 1'b1, kk);
    do_consume();
    load_key(2'd1, 2'd1, 6, 8'h20, 2'd1, 1'b1, kk);
`else
    load_key(2'd2, 2'd2, 4, 8'h80, 2'd0, 1'b1, kk);
`endif
    do_consume();
    load_key(2'd3, 2'd3, 4, 8'hC0, 2'd0, 1'b0, kk);
    do_consume();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 256'(sb.size()), 256'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
